// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and constants for the Sobel frame sequencer
package sobel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int          H_ACTIVE_DEF    = 640;
   localparam int          V_ACTIVE_DEF    = 480;
   localparam logic [7:0]  THRESH_INIT_DEF = 8'd64;
   localparam logic [15:0] FLUSH_PIX       = 16'h0000;

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// rtl/sobel_frame_ctrl_if.sv - pixel, config and gray-stage signal bundle
interface sobel_frame_ctrl_if
   import sobel_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF
);
   localparam int COL_W = $clog2(H_ACTIVE);
   localparam int ROW_W = $clog2(V_ACTIVE + 1);

   logic             vsync_in;
   logic [15:0]      pix_data_in;
   logic             pix_flag_in;
   logic             cfg_we;
   logic [7:0]       cfg_thresh;
   logic [15:0]      gray_ip_data;
   logic             gray_ip_flag;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic             win_valid;
   logic [7:0]       thresh_out;
   logic             busy;
   logic             frame_done;
   logic             err_short;
   logic             err_extra;

   modport master (
      output vsync_in, pix_data_in, pix_flag_in, cfg_we, cfg_thresh,
      input  gray_ip_data, gray_ip_flag, row, col, win_valid, thresh_out,
             busy, frame_done, err_short, err_extra
   );

   modport slave (
      input  vsync_in, pix_data_in, pix_flag_in, cfg_we, cfg_thresh,
      output gray_ip_data, gray_ip_flag, row, col, win_valid, thresh_out,
             busy, frame_done, err_short, err_extra
   );

endinterface

// File: rtl/pix_pos_cnt.sv
// rtl/pix_pos_cnt.sv - column/row position counter with clear and increment
module pix_pos_cnt #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int COL_W    = $clog2(H_ACTIVE),
   parameter int ROW_W    = $clog2(V_ACTIVE + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [COL_W-1:0] col_o,
   output logic [ROW_W-1:0] row_o
);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
   localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(V_ACTIVE);

   logic [COL_W-1:0] col_q, col_d, col_base;
   logic [ROW_W-1:0] row_q, row_d, row_base;

   // Clear and increment can coincide: the position after is (0,1).
   // Row stops at V_ACTIVE so the trailing flush pixel cannot overflow it.
   always_comb begin
      col_base = clr_i ? '0 : col_q;
      row_base = clr_i ? '0 : row_q;
      col_d    = col_base;
      row_d    = row_base;
      if (inc_i) begin
         if (col_base == COL_LAST) begin
            col_d = '0;
            if (row_base != ROW_MAX) row_d = row_base + 1'b1;
         end else begin
            col_d = col_base + 1'b1;
         end
      end
   end

   // Position registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o = col_base;
   assign row_o = row_base;

endmodule

// File: rtl/sobel_frame_ctrl.sv
// rtl/sobel_frame_ctrl.sv - frame sequencer feeding the Sobel gray stage
module sobel_frame_ctrl
   import sobel_pkg::*;
#(
   parameter int         H_ACTIVE    = H_ACTIVE_DEF,
   parameter int         V_ACTIVE    = V_ACTIVE_DEF,
   parameter logic [7:0] THRESH_INIT = THRESH_INIT_DEF
) (
   input  logic               tft_clk,
   input  logic               tft_rst,
   sobel_frame_ctrl_if.slave  bus
);
   localparam int COL_W = $clog2(H_ACTIVE);
   localparam int ROW_W = $clog2(V_ACTIVE + 1);
   localparam int CNT_W = $clog2(H_ACTIVE * V_ACTIVE + H_ACTIVE + 2);
   localparam logic [CNT_W-1:0] WIN_FIRST  = CNT_W'(H_ACTIVE + 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(H_ACTIVE * V_ACTIVE + H_ACTIVE);
   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(H_ACTIVE - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(V_ACTIVE - 1);

   state_e           state_q, state_d;
   logic             pend_q, pend_d;
   logic [7:0]       shadow_q, shadow_d, thresh_q, thresh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, emit_idx;
   logic [15:0]      data_q, data_d, emit_data;
   logic             flag_q, flag_d, win_q, win_d;
   logic [ROW_W-1:0] row_q, row_d, pos_row, emit_row;
   logic [COL_W-1:0] col_q, col_d, pos_col, emit_col;
   logic             busy_q, busy_d, done_q, done_d;
   logic             err_s_q, err_s_d, err_x_q, err_x_d;
   logic             emit, clr, load_thr, last_pix;

   // Position of the next pixel to be emitted, shared by ACTIVE and FLUSH.
   pix_pos_cnt #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .COL_W    (COL_W),
      .ROW_W    (ROW_W)
   ) u_pos (
      .clk_i  (tft_clk),
      .rst_ni (tft_rst),
      .clr_i  (clr),
      .inc_i  (emit),
      .col_o  (pos_col),
      .row_o  (pos_row)
   );

   assign last_pix = (pos_row == ROW_LAST) && (pos_col == COL_LAST);

   // State register.
   always_ff @(posedge tft_clk or negedge tft_rst) begin
      if (!tft_rst) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next state: a restart vsync in ACTIVE keeps us in ACTIVE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus.vsync_in || pend_q) state_d = ST_ACTIVE;
         ST_ACTIVE: if (!bus.vsync_in && bus.pix_flag_in && last_pix) state_d = ST_FLUSH;
         ST_FLUSH:  if (cnt_q == FLUSH_LAST) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Per-state controls and next values of every registered output.
   always_comb begin
      emit      = 1'b0;
      clr       = 1'b0;
      load_thr  = 1'b0;
      emit_data = bus.pix_data_in;
      err_s_d   = 1'b0;
      err_x_d   = 1'b0;
      pend_d    = pend_q;
      case (state_q)
         ST_IDLE: begin
            err_x_d = bus.pix_flag_in;
            if (bus.vsync_in || pend_q) begin
               clr      = 1'b1;
               load_thr = 1'b1;
               pend_d   = 1'b0;
            end
         end
         ST_ACTIVE: begin
            emit = bus.pix_flag_in;
            if (bus.vsync_in) begin
               clr      = 1'b1;
               load_thr = 1'b1;
               err_s_d  = 1'b1;
            end
         end
         ST_FLUSH: begin
            emit      = 1'b1;
            emit_data = FLUSH_PIX;
            err_x_d   = bus.pix_flag_in;
            if (bus.vsync_in) pend_d = 1'b1;
         end
         default: begin
            err_x_d = bus.pix_flag_in;
            if (bus.vsync_in) pend_d = 1'b1;
         end
      endcase
      emit_idx = clr ? '0 : cnt_q;
      emit_row = clr ? '0 : pos_row;
      emit_col = clr ? '0 : pos_col;
      cnt_d    = emit_idx + CNT_W'(emit);
      flag_d   = emit;
      data_d   = emit ? emit_data : 16'h0000;
      row_d    = emit ? emit_row : row_q;
      col_d    = emit ? emit_col : col_q;
      win_d    = emit && (emit_idx >= WIN_FIRST);
      shadow_d = bus.cfg_we ? bus.cfg_thresh : shadow_q;
      thresh_d = load_thr ? shadow_d : thresh_q;
      busy_d   = (state_d != ST_IDLE);
      done_d   = (state_q == ST_DONE);
   end

   // Datapath and output registers.
   always_ff @(posedge tft_clk or negedge tft_rst) begin
      if (!tft_rst) begin
         pend_q   <= 1'b0;
         shadow_q <= THRESH_INIT;
         thresh_q <= THRESH_INIT;
         cnt_q    <= '0;
         data_q   <= '0;
         flag_q   <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         win_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_s_q  <= 1'b0;
         err_x_q  <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         shadow_q <= shadow_d;
         thresh_q <= thresh_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         flag_q   <= flag_d;
         row_q    <= row_d;
         col_q    <= col_d;
         win_q    <= win_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_s_q  <= err_s_d;
         err_x_q  <= err_x_d;
      end
   end

   assign bus.gray_ip_data = data_q;
   assign bus.gray_ip_flag = flag_q;
   assign bus.row          = row_q;
   assign bus.col          = col_q;
   assign bus.win_valid    = win_q;
   assign bus.thresh_out   = thresh_q;
   assign bus.busy         = busy_q;
   assign bus.frame_done   = done_q;
   assign bus.err_short    = err_s_q;
   assign bus.err_extra    = err_x_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb/tb_sobel_frame_ctrl.sv - directed self-checking bench for sobel_frame_ctrl
module tb_sobel_frame_ctrl;
   localparam int H = 4;
   localparam int V = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sobel_frame_ctrl_if #(.H_ACTIVE(H), .V_ACTIVE(V)) bus ();

   sobel_frame_ctrl #(
      .H_ACTIVE    (H),
      .V_ACTIVE    (V),
      .THRESH_INIT (8'd64)
   ) dut (
      .tft_clk (clk),
      .tft_rst (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [15:0] d;
      int          r;
      int          c;
      logic        w;
      int          t;
   } rec_t;

   rec_t recs[$];
   int   fd_t[$];
   int   es_t[$];
   int   ex_t[$];
   int   edge_n = 0;
   int   checks = 0;
   int   errors = 0;
   int   pix_e[12];
   int   gap_tbl[12] = '{0, 2, 1, 0, 3, 0, 1, 0, 0, 2, 0, 1};

   // Edge counter used to time-stamp every observed output.
   always @(posedge clk) edge_n <= edge_n + 1;

   // Collect emitted pixels and pulse outputs, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.gray_ip_flag)
            recs.push_back('{bus.gray_ip_data, int'(bus.row), int'(bus.col), bus.win_valid, edge_n});
         if (bus.frame_done) fd_t.push_back(edge_n);
         if (bus.err_short)  es_t.push_back(edge_n);
         if (bus.err_extra)  ex_t.push_back(edge_n);
      end
   end

   task automatic clear_logs();
      recs.delete();
      fd_t.delete();
      es_t.delete();
      ex_t.delete();
   endtask

   task automatic cyc(input logic vs, input logic pf, input logic [15:0] pd, output int e);
      bus.vsync_in    = vs;
      bus.pix_flag_in = pf;
      bus.pix_data_in = pd;
      @(posedge clk);
      #1;
      e = edge_n;
      bus.vsync_in    = 1'b0;
      bus.pix_flag_in = 1'b0;
      bus.pix_data_in = 16'h0000;
      bus.cfg_we      = 1'b0;
   endtask

   task automatic idle(input int n);
      int e;
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, e);
   endtask

   task automatic send_pixels(input logic [15:0] base, input int n, input bit gapped);
      int e;
      for (int i = 0; i < n; i++) begin
         if (gapped) idle(gap_tbl[i % 12]);
         cyc(1'b0, 1'b1, base + 16'(i), e);
         pix_e[i] = e;
      end
   endtask

   task automatic do_reset();
      bus.vsync_in    = 1'b0;
      bus.pix_flag_in = 1'b0;
      bus.pix_data_in = 16'h0000;
      bus.cfg_we      = 1'b0;
      bus.cfg_thresh  = 8'h00;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic test_reset();
      bus.vsync_in    = 1'b0;
      bus.pix_flag_in = 1'b0;
      bus.pix_data_in = 16'h0000;
      bus.cfg_we      = 1'b0;
      bus.cfg_thresh  = 8'h00;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.gray_ip_flag !== 1'b0 || bus.gray_ip_data !== 16'h0000 || bus.win_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_gray flag=%b data=%h win=%b expected 0 0000 0", bus.gray_ip_flag, bus.gray_ip_data, bus.win_valid);
      end
      checks++;
      if (bus.row !== 2'd0 || bus.col !== 2'd0) begin
         errors++;
         $display("FAIL reset_pos row=%0d col=%0d expected 0 0", bus.row, bus.col);
      end
      checks++;
      if (bus.thresh_out !== 8'h40) begin
         errors++;
         $display("FAIL reset_thresh got %h expected 40", bus.thresh_out);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.err_short !== 1'b0 || bus.err_extra !== 1'b0) begin
         errors++;
         $display("FAIL reset_status busy=%b done=%b es=%b ex=%b expected 0 0 0 0", bus.busy, bus.frame_done, bus.err_short, bus.err_extra);
      end
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic test_clean_frame();
      int e;
      clear_logs();
      cyc(1'b1, 1'b0, 16'h0000, e);
      send_pixels(16'hA500, 12, 1'b0);
      idle(10);
      checks++;
      if (recs.size() != 17) begin
         errors++;
         $display("FAIL clean_count got %0d expected 17", recs.size());
      end
      for (int k = 0; k < 17; k++) begin
         logic [15:0] ed;
         int          er, ec, et;
         logic        ew;
         ed = (k < 12) ? 16'hA500 + 16'(k) : 16'h0000;
         er = (k < 12) ? k / 4 : 3;
         ec = (k < 12) ? k % 4 : (k - 12) % 4;
         ew = (k >= 5);
         et = pix_e[0] + k;
         checks++;
         if (k >= recs.size()) begin
            errors++;
            $display("FAIL clean_rec%0d missing", k);
         end else if (recs[k].d !== ed || recs[k].r != er || recs[k].c != ec || recs[k].w !== ew || recs[k].t != et) begin
            errors++;
            $display("FAIL clean_rec%0d got d=%h r=%0d c=%0d w=%b t=%0d expected d=%h r=%0d c=%0d w=%b t=%0d",
                     k, recs[k].d, recs[k].r, recs[k].c, recs[k].w, recs[k].t, ed, er, ec, ew, et);
         end
      end
      checks++;
      if (fd_t.size() != 1 || (fd_t.size() == 1 && fd_t[0] != pix_e[11] + 6)) begin
         errors++;
         $display("FAIL clean_done count=%0d first=%0d expected 1 at %0d", fd_t.size(), (fd_t.size() > 0) ? fd_t[0] : -1, pix_e[11] + 6);
      end
      checks++;
      if (bus.row !== 2'd3 || bus.busy !== 1'b0 || es_t.size() != 0 || ex_t.size() != 0) begin
         errors++;
         $display("FAIL clean_end row=%0d busy=%b es=%0d ex=%0d expected 3 0 0 0", bus.row, bus.busy, es_t.size(), ex_t.size());
      end
   endtask

   task automatic test_gapped();
      int e;
      clear_logs();
      cyc(1'b1, 1'b0, 16'h0000, e);
      send_pixels(16'h3300, 12, 1'b1);
      idle(10);
      checks++;
      if (recs.size() != 17) begin
         errors++;
         $display("FAIL gap_count got %0d expected 17", recs.size());
      end
      for (int k = 0; k < 17 && k < recs.size(); k++) begin
         logic [15:0] ed;
         int          et;
         ed = (k < 12) ? 16'h3300 + 16'(k) : 16'h0000;
         et = (k < 12) ? pix_e[k] : pix_e[11] + (k - 11);
         checks++;
         if (recs[k].d !== ed || recs[k].t != et) begin
            errors++;
            $display("FAIL gap_rec%0d got d=%h t=%0d expected d=%h t=%0d", k, recs[k].d, recs[k].t, ed, et);
         end
      end
      checks++;
      if (fd_t.size() != 1) begin
         errors++;
         $display("FAIL gap_done got %0d pulses expected 1", fd_t.size());
      end
   endtask

   task automatic test_early_restart();
      int e, r0, wins;
      clear_logs();
      cyc(1'b1, 1'b0, 16'h0000, e);
      send_pixels(16'hA500, 7, 1'b0);
      cyc(1'b1, 1'b1, 16'hC000, r0);
      send_pixels(16'hC001, 11, 1'b0);
      idle(10);
      checks++;
      if (es_t.size() != 1 || (es_t.size() == 1 && es_t[0] != r0)) begin
         errors++;
         $display("FAIL restart_err_short count=%0d expected 1 at %0d", es_t.size(), r0);
      end
      checks++;
      if (recs.size() != 24) begin
         errors++;
         $display("FAIL restart_count got %0d expected 24", recs.size());
      end else begin
         checks++;
         if (recs[7].d !== 16'hC000 || recs[7].r != 0 || recs[7].c != 0 || recs[7].w !== 1'b0 || recs[7].t != r0) begin
            errors++;
            $display("FAIL restart_first got d=%h r=%0d c=%0d w=%b t=%0d expected C000 0 0 0 %0d",
                     recs[7].d, recs[7].r, recs[7].c, recs[7].w, recs[7].t, r0);
         end
         checks++;
         if (recs[8].c != 1 || recs[11].w !== 1'b0 || recs[12].w !== 1'b1) begin
            errors++;
            $display("FAIL restart_win c8=%0d w11=%b w12=%b expected 1 0 1", recs[8].c, recs[11].w, recs[12].w);
         end
         checks++;
         if (recs[18].d !== 16'hC00B || recs[18].r != 2 || recs[18].c != 3) begin
            errors++;
            $display("FAIL restart_last got d=%h r=%0d c=%0d expected C00B 2 3", recs[18].d, recs[18].r, recs[18].c);
         end
         wins = 0;
         foreach (recs[i]) if (recs[i].w) wins++;
         checks++;
         if (wins != 14) begin
            errors++;
            $display("FAIL restart_wins got %0d expected 14", wins);
         end
      end
      checks++;
      if (fd_t.size() != 1) begin
         errors++;
         $display("FAIL restart_done got %0d pulses expected 1", fd_t.size());
      end
   endtask

   task automatic test_vsync_flush();
      int e, le;
      clear_logs();
      cyc(1'b1, 1'b0, 16'h0000, e);
      send_pixels(16'hA500, 12, 1'b0);
      le = pix_e[11];
      cyc(1'b0, 1'b0, 16'h0000, e);
      cyc(1'b1, 1'b0, 16'h0000, e);
      idle(3);
      checks++;
      if (bus.busy !== 1'b1 || bus.frame_done !== 1'b0) begin
         errors++;
         $display("FAIL vflush_done_state busy=%b done=%b expected 1 0", bus.busy, bus.frame_done);
      end
      idle(1);
      checks++;
      if (bus.busy !== 1'b0 || bus.frame_done !== 1'b1) begin
         errors++;
         $display("FAIL vflush_idle busy=%b done=%b expected 0 1", bus.busy, bus.frame_done);
      end
      idle(1);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL vflush_pending_start busy=%b expected 1", bus.busy);
      end
      send_pixels(16'hB500, 12, 1'b0);
      idle(10);
      checks++;
      if (recs.size() != 34) begin
         errors++;
         $display("FAIL vflush_count got %0d expected 34", recs.size());
      end else begin
         for (int k = 12; k < 17; k++) begin
            checks++;
            if (recs[k].d !== 16'h0000 || recs[k].t != le + (k - 11)) begin
               errors++;
               $display("FAIL vflush_pad%0d got d=%h t=%0d expected 0000 %0d", k - 12, recs[k].d, recs[k].t, le + (k - 11));
            end
         end
         checks++;
         if (recs[17].d !== 16'hB500 || recs[17].r != 0 || recs[17].c != 0 || recs[17].t != pix_e[0]) begin
            errors++;
            $display("FAIL vflush_next got d=%h r=%0d c=%0d t=%0d expected B500 0 0 %0d",
                     recs[17].d, recs[17].r, recs[17].c, recs[17].t, pix_e[0]);
         end
      end
      checks++;
      if (fd_t.size() != 2 || es_t.size() != 0 || ex_t.size() != 0) begin
         errors++;
         $display("FAIL vflush_pulses done=%0d es=%0d ex=%0d expected 2 0 0", fd_t.size(), es_t.size(), ex_t.size());
      end
   endtask

   task automatic test_threshold();
      int e;
      clear_logs();
      checks++;
      if (bus.thresh_out !== 8'h40) begin
         errors++;
         $display("FAIL thr_initial got %h expected 40", bus.thresh_out);
      end
      cyc(1'b1, 1'b0, 16'h0000, e);
      send_pixels(16'h1100, 5, 1'b0);
      bus.cfg_we     = 1'b1;
      bus.cfg_thresh = 8'hA0;
      cyc(1'b0, 1'b1, 16'h1105, e);
      checks++;
      if (bus.thresh_out !== 8'h40) begin
         errors++;
         $display("FAIL thr_midframe got %h expected 40", bus.thresh_out);
      end
      send_pixels(16'h1106, 6, 1'b0);
      idle(10);
      checks++;
      if (bus.thresh_out !== 8'h40) begin
         errors++;
         $display("FAIL thr_idle got %h expected 40", bus.thresh_out);
      end
      cyc(1'b1, 1'b0, 16'h0000, e);
      checks++;
      if (bus.thresh_out !== 8'hA0) begin
         errors++;
         $display("FAIL thr_new_frame got %h expected A0", bus.thresh_out);
      end
      send_pixels(16'h1200, 12, 1'b0);
      idle(10);
      bus.cfg_we     = 1'b1;
      bus.cfg_thresh = 8'h55;
      cyc(1'b1, 1'b0, 16'h0000, e);
      checks++;
      if (bus.thresh_out !== 8'h55) begin
         errors++;
         $display("FAIL thr_same_cycle got %h expected 55", bus.thresh_out);
      end
      send_pixels(16'h1300, 12, 1'b0);
      idle(10);
   endtask

   task automatic test_stray_and_reset();
      int e, e0, le;
      do_reset();
      cyc(1'b0, 1'b1, 16'hBEEF, e0);
      idle(2);
      checks++;
      if (ex_t.size() != 1 || (ex_t.size() == 1 && ex_t[0] != e0) || recs.size() != 0) begin
         errors++;
         $display("FAIL stray_idle ex=%0d recs=%0d expected 1 at %0d, 0 recs", ex_t.size(), recs.size(), e0);
      end
      cyc(1'b1, 1'b0, 16'h0000, e);
      send_pixels(16'hA500, 12, 1'b0);
      le = pix_e[11];
      cyc(1'b0, 1'b1, 16'hFFFF, e);
      cyc(1'b0, 1'b1, 16'hFFFF, e);
      idle(10);
      checks++;
      if (recs.size() != 17 || ex_t.size() != 3 || fd_t.size() != 1) begin
         errors++;
         $display("FAIL stray_flush recs=%0d ex=%0d done=%0d expected 17 3 1", recs.size(), ex_t.size(), fd_t.size());
      end else begin
         for (int k = 12; k < 17; k++) begin
            checks++;
            if (recs[k].d !== 16'h0000 || recs[k].t != le + (k - 11)) begin
               errors++;
               $display("FAIL stray_pad%0d got d=%h t=%0d expected 0000 %0d", k - 12, recs[k].d, recs[k].t, le + (k - 11));
            end
         end
      end
      bus.cfg_we     = 1'b1;
      bus.cfg_thresh = 8'h99;
      cyc(1'b1, 1'b0, 16'h0000, e);
      send_pixels(16'hD000, 5, 1'b0);
      checks++;
      if (bus.thresh_out !== 8'h99 || bus.gray_ip_flag !== 1'b1) begin
         errors++;
         $display("FAIL prereset thr=%h flag=%b expected 99 1", bus.thresh_out, bus.gray_ip_flag);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.gray_ip_flag !== 1'b0 || bus.gray_ip_data !== 16'h0000 || bus.row !== 2'd0 || bus.col !== 2'd0 ||
          bus.win_valid !== 1'b0 || bus.thresh_out !== 8'h40 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0 ||
          bus.err_short !== 1'b0 || bus.err_extra !== 1'b0) begin
         errors++;
         $display("FAIL async_reset flag=%b data=%h row=%0d col=%0d win=%b thr=%h busy=%b done=%b es=%b ex=%b expected all 0, thr 40",
                  bus.gray_ip_flag, bus.gray_ip_data, bus.row, bus.col, bus.win_valid, bus.thresh_out,
                  bus.busy, bus.frame_done, bus.err_short, bus.err_extra);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_logs();
      idle(4);
      checks++;
      if (recs.size() != 0 || fd_t.size() != 0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset recs=%0d done=%0d busy=%b expected 0 0 0", recs.size(), fd_t.size(), bus.busy);
      end
   endtask

   initial begin
      test_reset();
      test_clean_frame();
      test_gapped();
      test_early_restart();
      test_vsync_flush();
      test_threshold();
      test_stray_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame sequencer for the Sobel edge path. It takes the raw RGB565 pixel stream and drives the gray-conversion stage's input pair (`gray_ip_data`/`gray_ip_flag`). It tracks row and column position and injects flush pixels after the last real pixel so the downstream 3×3 line buffers drain fully. It also tells downstream which pixels carry a complete window, and latches the edge threshold once per frame.

## Interface
- `H_ACTIVE`, 640, active pixels per line (≥3)
- `V_ACTIVE`, 480, active lines per frame (≥3)
- `THRESH_INIT`, 8'd64, reset value of shadow and active threshold
- `tft_clk` in 1: pixel clock; single clock domain
- `tft_rst` in 1: asynchronous, active-low reset
- `vsync_in` in 1: one-cycle frame-start pulse
- `pix_data_in` in 16: RGB565 pixel
- `pix_flag_in` in 1: `pix_data_in` valid this cycle
- `cfg_we` in 1: write strobe for `cfg_thresh`
- `cfg_thresh` in 8: new threshold value
- `gray_ip_data` out 16: pixel to gray stage
- `gray_ip_flag` out 1: `gray_ip_data` valid
- `row` out clog2(V_ACTIVE+1): row of the pixel on `gray_ip_*`
- `col` out clog2(H_ACTIVE): column of the pixel on `gray_ip_*`
- `win_valid` out 1: pixel on `gray_ip_*` completes a 3×3 window
- `thresh_out` out 8: threshold active for the current frame
- `busy` out 1: state ≠ IDLE
- `frame_done` out 1: one-cycle pulse at end of flush
- `err_short` out 1: one-cycle pulse; frame restarted before completion
- `err_extra` out 1: one-cycle pulse; pixel arrived outside ACTIVE

## Operation
- **States:**
  - IDLE: waits for a frame start.
  - ACTIVE: forwards real pixels.
  - FLUSH: injects padding pixels.
  - DONE: ends the frame; lasts one cycle.
- **IDLE → ACTIVE:** on `vsync_in`, or on a pending vsync. Column, row and the emitted-pixel counter (`out_cnt`) clear. `thresh_out` ← shadow threshold.
- **ACTIVE:**
  - Each `pix_flag_in` forwards `pix_data_in` to `gray_ip_*` and increments `out_cnt`.
  - `col` wraps from H_ACTIVE-1 to 0; `row` increments on each wrap.
  - Acceptance of pixel (V_ACTIVE-1, H_ACTIVE-1) → FLUSH.
- **FLUSH:**
  - Emits exactly H_ACTIVE+1 pixels, one per cycle, each with data 16'h0000 and the flag high.
  - `row`/`col` keep counting; `row` reaches V_ACTIVE.
  - After the last flush pixel → DONE.
- **DONE:** pulses `frame_done`, then → IDLE.
- **`win_valid`** = `gray_ip_flag` && `out_cnt` ≥ H_ACTIVE+1, where `out_cnt` is the index of the emitted pixel, zero-based. This gives exactly H_ACTIVE·V_ACTIVE `win_valid` pulses per frame.
- **`vsync_in` in ACTIVE:** the frame restarts immediately (counters clear, threshold reloads) and `err_short` pulses. A simultaneous `pix_flag_in` is taken as pixel (0,0) of the new frame.
- **`vsync_in` in FLUSH or DONE:** sets a pending flag and the flush is not cut short. The next IDLE cycle consumes the flag and enters ACTIVE.
- **`pix_flag_in` in IDLE, FLUSH or DONE:** the pixel is dropped and `err_extra` pulses.
- **`cfg_we`:** writes the shadow threshold at any time. It never changes `thresh_out` mid-frame. If `cfg_we` coincides with frame start, the new value is loaded.
- **Counter widths:** `out_cnt` is clog2(H_ACTIVE·V_ACTIVE + H_ACTIVE + 2) bits. Counters never wrap in a legal frame.

## Timing
- **Reset values:** all outputs 0, except `thresh_out` = THRESH_INIT. State IDLE, pending flag cleared. The shadow threshold resets to THRESH_INIT.
- **Latency:** all outputs are registered. There is 1 cycle from `pix_flag_in` to `gray_ip_flag`, and `row`/`col`/`win_valid` are aligned with `gray_ip_flag`.
- **`thresh_out`** updates on the cycle after the frame-start cycle.
- **Flush** starts the cycle after the last real pixel is accepted. It shows on `gray_ip_flag` from that cycle +1, contiguously for H_ACTIVE+1 cycles.
- **`frame_done`** goes high the cycle after the last flush pixel is presented.
- **Reset mid-frame:** takes effect immediately (asynchronous); no flush is performed.

## Structure
- A shared package `sobel_pkg` holds:
  - state encoding (IDLE/ACTIVE/FLUSH/DONE)
  - default H_ACTIVE/V_ACTIVE/THRESH_INIT
  - a flush-pixel constant of 16'h0000
- One sub-module, `pix_pos_cnt`: column/row counter with wrap, clear, and increment enable. It is instantiated once and shared between ACTIVE and FLUSH.

## Test plan
Each case uses H_ACTIVE=4, V_ACTIVE=3.
1. **Clean frame:** vsync, then 12 contiguous pixels → 12 forwarded, then 5 zero pixels. `win_valid` pulses 12 times, starting at `out_cnt`=5. `row` ends at 3. `frame_done` fires 1 cycle after the last flush pixel.
2. **Gapped input:** 12 pixels with random idle cycles → same output count, each pixel 1 cycle late. Flush still runs 5 contiguous cycles.
3. **Early restart:** vsync after 7 pixels → `err_short` pulses, `row`/`col` restart at 0, and the full frame then completes normally.
4. **Vsync during flush:** vsync on flush pixel 2 → all 5 flush pixels still emitted. DONE, then 1 IDLE cycle, then ACTIVE with no new vsync.
5. **Threshold:** `cfg_we`=1, `cfg_thresh`=8'hA0 mid-frame → `thresh_out` holds 8'h40 until the next frame start, then changes to 8'hA0.
6. **Stray pixels:** `pix_flag_in` in IDLE and during FLUSH → `err_extra` pulses, nothing forwarded, flush data stays 0. Then assert reset mid-ACTIVE → all outputs return to their reset values at once.
